// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//   Multi-channel pushbutton debouncer. Each raw button is passed through a
//   two-flop synchroniser and then filtered by a per-channel saturating
//   stability counter. The counter only advances on a shared prescaler strobe,
//   so a new level is accepted after STABLE_CNT consecutive strobes that all
//   disagree with the current debounced level.
//
// Ports
//   clk          in   1       system clock
//   rst          in   1       asynchronous reset, active-low
//   raw          in   N_KEYS  asynchronous, bouncy button inputs
//   db           out  N_KEYS  debounced, clk-synchronous levels
//   chg          out  N_KEYS  1-cycle pulse on the first cycle db[i] holds a new value
//   sample_tick  out  1       1-cycle prescaler strobe, once every PRESCALE clk
// -----------------------------------------------------------------------------

// Per-channel stability filter. Runs only on sample strobes; any strobe whose
// sample matches the current level throws away accumulated progress.
module key_debouncer_lane #(
   parameter int   STABLE_CNT = 10,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic s,
   output logic db,
   output logic chg
);

   localparam int            CW   = $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         db  <= IDLE_LEVEL;
         chg <= 1'b0;
      end else begin
         chg <= 1'b0;
         if (tick) begin
            if (s == db) begin
               cnt <= '0;
            end else if (cnt == CMAX) begin
               // Last required disagreeing strobe: accept the new level.
               db  <= s;
               cnt <= '0;
               chg <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

module key_debouncer #(
   parameter int   N_KEYS     = 8,
   parameter int   PRESCALE   = 50000,
   parameter int   STABLE_CNT = 10,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] raw,
   output logic [N_KEYS-1:0] db,
   output logic [N_KEYS-1:0] chg,
   output logic              sample_tick
);

   localparam int            PW   = $clog2(PRESCALE);
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   // Synchroniser as a 2-deep shift register: [0] first stage, [1] = s.
   logic [1:0][N_KEYS-1:0] sync_pipe;
   logic [PW-1:0]          pcnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_pipe <= {(2*N_KEYS){IDLE_LEVEL}};
      end else begin
         sync_pipe <= {sync_pipe[0], raw};
      end
   end

   // The strobe is registered off the wrap, so it lands PRESCALE cycles after
   // reset release and every PRESCALE cycles thereafter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt        <= '0;
         sample_tick <= 1'b0;
      end else if (pcnt == PMAX) begin
         pcnt        <= '0;
         sample_tick <= 1'b1;
      end else begin
         pcnt        <= pcnt + PW'(1);
         sample_tick <= 1'b0;
      end
   end

   for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
      key_debouncer_lane #(
         .STABLE_CNT (STABLE_CNT),
         .IDLE_LEVEL (IDLE_LEVEL)
      ) u_lane (
         .clk  (clk),
         .rst  (rst),
         .tick (sample_tick),
         .s    (sync_pipe[1][i]),
         .db   (db[i]),
         .chg  (chg[i])
      );
   end

endmodule
